// File: rtl/vga_timing_pattern_gen.sv
// vga_timing_pattern_gen: parametrised VGA raster timing with debounced, frame-synchronous test-pattern selection.
module vga_timing_pattern_gen #(
  parameter int H_ACT    = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACT    = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int SYNC_POL = 0,
  parameter int COLOR_W  = 4,
  parameter int CNT_W    = 12,
  parameter int DEBOUNCE = 250000,
  parameter int CHK_LOG2 = 5
) (
  input  logic               vga_clk,
  input  logic               rst_n,
  input  logic               pb_up,
  output logic               h_sync,
  output logic               v_sync,
  output logic               de,
  output logic [COLOR_W-1:0] red,
  output logic [COLOR_W-1:0] green,
  output logic [COLOR_W-1:0] blue,
  output logic [CNT_W-1:0]   pix_x,
  output logic [CNT_W-1:0]   pix_y,
  output logic               frame_start,
  output logic [3:0]         pattern_sel
);
  localparam int H_TOTAL = H_ACT + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACT + V_FP + V_SYNC + V_BP;
  localparam int BAR_W = H_ACT / 8;
  localparam int DB_W = $clog2(DEBOUNCE + 1);
  localparam logic SP = 1'(SYNC_POL);
  // {r,g,b} per colour index: white, black, red, green, blue, yellow, cyan, magenta
  localparam logic [23:0] SOLID = {3'b101, 3'b011, 3'b110, 3'b001, 3'b010, 3'b100, 3'b000, 3'b111};
  logic [CNT_W-1:0] h_cnt, v_cnt, bar_px;
  logic [2:0] bar_idx, bits;
  logic h_end, v_end, wrap, de_n, grad;
  logic sync0, sync1, sync2, db, db_d, rise, pending;
  logic [DB_W-1:0] db_cnt;
  logic [3:0] pat;
  logic [COLOR_W-1:0] r_n, g_n, b_n;
  assign h_end = h_cnt == CNT_W'(H_TOTAL - 1);
  assign v_end = v_cnt == CNT_W'(V_TOTAL - 1);
  assign wrap = h_end && v_end;
  assign rise = db && !db_d;
  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else begin
      h_cnt <= h_end ? '0 : h_cnt + 1'b1;
      if (h_end) v_cnt <= v_end ? '0 : v_cnt + 1'b1;
    end
  end
  // bar index tracks h_cnt with a per-bar pixel counter instead of a divider
  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      bar_px  <= '0;
      bar_idx <= '0;
    end else if (h_end) begin
      bar_px  <= '0;
      bar_idx <= '0;
    end else if (bar_px == CNT_W'(BAR_W - 1)) begin
      bar_px  <= '0;
      bar_idx <= (bar_idx == 3'd7) ? 3'd7 : bar_idx + 3'd1;
    end else begin
      bar_px <= bar_px + 1'b1;
    end
  end
  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      sync0   <= 1'b0;
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      db_cnt  <= '0;
      db      <= 1'b0;
      db_d    <= 1'b0;
      pending <= 1'b0;
      pat     <= '0;
    end else begin
      sync0 <= pb_up;
      sync1 <= sync0;
      sync2 <= sync1;
      if (sync1 != sync2) db_cnt <= '0;
      else if (db_cnt == DB_W'(DEBOUNCE - 1)) db <= sync2;
      else db_cnt <= db_cnt + 1'b1;
      db_d <= db;
      // a rise landing on the wrap cycle stays pending for the next frame
      if (wrap) begin
        pending <= rise;
        if (pending || pat > 4'd10) pat <= (pat >= 4'd10) ? 4'd0 : pat + 4'd1;
      end else begin
        pending <= pending || rise;
      end
    end
  end
  always_comb begin
    de_n = (h_cnt < CNT_W'(H_ACT)) && (v_cnt < CNT_W'(V_ACT));
    grad = pat == 4'd10;
    bits = pat < 4'd8 ? SOLID[3*pat[2:0] +: 3] :
           pat == 4'd8 ? SOLID[3*bar_idx +: 3] :
           pat == 4'd9 ? {3{~(h_cnt[CHK_LOG2] ^ v_cnt[CHK_LOG2])}} : 3'b111;
    r_n = !de_n ? '0 : grad ? h_cnt[COLOR_W+1:2] : {COLOR_W{bits[2]}};
    g_n = !de_n ? '0 : grad ? v_cnt[COLOR_W+1:2] : {COLOR_W{bits[1]}};
    b_n = (!de_n || grad) ? '0 : {COLOR_W{bits[0]}};
  end
  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      h_sync      <= ~SP;
      v_sync      <= ~SP;
      de          <= 1'b0;
      red         <= '0;
      green       <= '0;
      blue        <= '0;
      pix_x       <= '0;
      pix_y       <= '0;
      frame_start <= 1'b0;
      pattern_sel <= '0;
    end else begin
      h_sync      <= (h_cnt >= CNT_W'(H_ACT + H_FP) && h_cnt < CNT_W'(H_ACT + H_FP + H_SYNC)) ? SP : ~SP;
      v_sync      <= (v_cnt >= CNT_W'(V_ACT + V_FP) && v_cnt < CNT_W'(V_ACT + V_FP + V_SYNC)) ? SP : ~SP;
      de          <= de_n;
      red         <= r_n;
      green       <= g_n;
      blue        <= b_n;
      pix_x       <= h_cnt;
      pix_y       <= v_cnt;
      frame_start <= h_cnt == '0 && v_cnt == '0;
      pattern_sel <= pat;
    end
  end
endmodule

// File: tb/tb_vga_timing_pattern_gen.sv
// tb_vga_timing_pattern_gen: directed checks on a small raster (26x12, active-high sync) plus default 640x480 line timing.
module tb_vga_timing_pattern_gen;
  logic clk = 1'b0, rst_n = 1'b0, pb_up = 1'b0;
  logic s_hs, s_vs, s_de, s_fs, d_hs, d_vs, d_de, d_fs;
  logic [3:0] s_r, s_g, s_b, d_r, d_g, d_b, s_pat, d_pat;
  logic [11:0] s_x, s_y, d_x, d_y;
  int checks = 0, errors = 0;
  logic [11:0] exp_rgb [0:7] = '{12'hFFF, 12'h000, 12'hF00, 12'h0F0, 12'h00F, 12'hFF0, 12'h0FF, 12'hF0F};
  int bar_x [0:9] = '{0, 2, 4, 7, 9, 11, 13, 15, 17, 18};
  logic [12:0] bar_e [0:9] = '{13'h1FFF, 13'h1000, 13'h1F00, 13'h10F0, 13'h100F,
                              13'h1FF0, 13'h10FF, 13'h1F0F, 13'h1F0F, 13'h0000};

  always #5 clk = ~clk;

  vga_timing_pattern_gen #(
    .H_ACT(18), .H_FP(2), .H_SYNC(3), .H_BP(3), .V_ACT(8), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .SYNC_POL(1), .COLOR_W(4), .CNT_W(12), .DEBOUNCE(16), .CHK_LOG2(1)
  ) u_small (
    .vga_clk(clk), .rst_n(rst_n), .pb_up(pb_up), .h_sync(s_hs), .v_sync(s_vs), .de(s_de),
    .red(s_r), .green(s_g), .blue(s_b), .pix_x(s_x), .pix_y(s_y), .frame_start(s_fs), .pattern_sel(s_pat)
  );

  vga_timing_pattern_gen #(.DEBOUNCE(16)) u_def (
    .vga_clk(clk), .rst_n(rst_n), .pb_up(pb_up), .h_sync(d_hs), .v_sync(d_vs), .de(d_de),
    .red(d_r), .green(d_g), .blue(d_b), .pix_x(d_x), .pix_y(d_y), .frame_start(d_fs), .pattern_sel(d_pat)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_pix(input int x, input int y);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(s_x == 12'(x) && s_y == 12'(y)) && n < 700);
    chk("wait_pix", 32'(n < 700), 1);
  endtask

  task automatic wait_frame();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!s_fs && n < 700);
    chk("wait_frame", 32'(n < 700), 1);
  endtask

  task automatic press(input int p);
    pb_up = 1'b1;
    repeat (40) @(negedge clk);
    pb_up = 1'b0;
    repeat (40) @(negedge clk);
    wait_frame();
    chk("press_pattern", 32'(s_pat), 32'(p));
  endtask

  initial begin
    int n;
    logic early;
    repeat (3) @(negedge clk);
    chk("rst_small_hs", 32'(s_hs), 0);
    chk("rst_small_de_rgb", {s_de, s_r, s_g, s_b}, 0);
    chk("rst_small_fs_pat", {s_fs, s_pat}, 0);
    chk("rst_def_sync", {d_hs, d_vs}, 2'b11);
    rst_n = 1'b1;
    @(negedge clk);
    chk("first_small", {s_fs, s_de, s_x, s_y, s_r, s_g, s_b}, {2'b11, 24'd0, 12'hFFF});
    chk("first_def", {d_fs, d_de, d_hs, d_vs, d_pat, d_x, d_r, d_g, d_b}, {4'b1111, 4'd0, 12'd0, 12'hFFF});
    repeat (639) @(negedge clk);
    chk("def_639", {d_x, d_de, d_hs}, {12'd639, 2'b11});
    @(negedge clk);
    chk("def_640", {d_x, d_de, d_hs}, {12'd640, 2'b01});
    repeat (16) @(negedge clk);
    chk("def_656", {d_x, d_hs}, {12'd656, 1'b0});
    repeat (95) @(negedge clk);
    chk("def_751", {d_x, d_hs}, {12'd751, 1'b0});
    @(negedge clk);
    chk("def_752", {d_x, d_y, d_hs, d_vs}, {12'd752, 12'd0, 2'b11});

    wait_pix(17, 0); chk("s_de_17", {s_de, s_hs}, 2'b10);
    wait_pix(18, 0); chk("s_de_18", {s_de, s_r, s_g, s_b}, 0);
    wait_pix(19, 0); chk("s_hs_19", 32'(s_hs), 0);
    wait_pix(20, 0); chk("s_hs_20", 32'(s_hs), 1);
    wait_pix(22, 0); chk("s_hs_22", 32'(s_hs), 1);
    wait_pix(23, 0); chk("s_hs_23", 32'(s_hs), 0);
    wait_pix(0, 8);  chk("s_vs_8", {s_de, s_vs}, 0);
    wait_pix(0, 9);  chk("s_vs_9", 32'(s_vs), 1);
    wait_pix(25, 10); chk("s_vs_10", 32'(s_vs), 1);
    wait_pix(0, 11); chk("s_vs_11", 32'(s_vs), 0);

    wait_frame();
    for (int i = 0; i < 100; i++) begin
      if (i % 3 == 0) pb_up = ~pb_up;
      @(negedge clk);
    end
    pb_up = 1'b1;
    early = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (!s_fs && s_pat != 4'd0) early = 1'b1;
    end while (!s_fs && n < 700);
    chk("t3_no_midframe", 32'(early), 0);
    chk("t3_frame_seen", 32'(n < 700), 1);
    chk("t3_new_pattern", {s_pat, s_x, s_y, s_de, s_r, s_g, s_b}, {4'd1, 24'd0, 1'b1, 12'h000});
    pb_up = 1'b0;
    repeat (40) @(negedge clk);
    wait_frame();
    chk("t3_single_inc", 32'(s_pat), 1);

    for (int p = 2; p <= 7; p++) begin
      press(p);
      chk("solid_rgb", {s_r, s_g, s_b}, exp_rgb[p]);
    end
    press(8);
    for (int i = 0; i < 10; i++) begin
      wait_pix(bar_x[i], 1);
      chk("bar", {s_de, s_r, s_g, s_b}, bar_e[i]);
    end
    press(9);
    chk("chk_0_0", {s_r, s_g, s_b}, 12'hFFF);
    wait_pix(2, 0); chk("chk_2_0", {s_r, s_g, s_b}, 12'h000);
    wait_pix(1, 2); chk("chk_1_2", {s_r, s_g, s_b}, 12'h000);
    wait_pix(2, 2); chk("chk_2_2", {s_r, s_g, s_b}, 12'hFFF);
    wait_pix(3, 3); chk("chk_3_3", {s_r, s_g, s_b}, 12'hFFF);
    press(10);
    wait_pix(3, 0);  chk("grad_3_0", {s_r, s_g, s_b}, 12'h000);
    wait_pix(8, 4);  chk("grad_8_4", {s_r, s_g, s_b}, 12'h210);
    wait_pix(17, 5); chk("grad_17_5", {s_r, s_g, s_b}, 12'h410);
    wait_pix(20, 5); chk("grad_blank", {s_de, s_r, s_g, s_b}, 0);
    press(0);
    chk("wrap_white", {s_r, s_g, s_b}, 12'hFFF);
    press(1);

    wait_pix(10, 5);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_pix", {s_x, s_y}, 0);
    chk("t6_rst_out", {s_hs, s_vs, s_de, s_fs, s_pat, s_r, s_g, s_b}, 0);
    chk("t6_rst_def", {d_hs, d_vs, d_de, d_x}, {3'b110, 12'd0});
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("t6_first_fs", {s_fs, s_x, s_y}, {1'b1, 24'd0});
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!s_fs && n < 400);
    chk("t6_frame_len", n, 312);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
